load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: byte/halfword/word access to a word-wide data memory, with sub-word
// stores done as read-merge-write. Optional macro LSU_MISALIGN_TRAP_EN traps misaligned requests.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        misalign
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WR   = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [31:0] merge_r;
    logic [31:0] waddr_r;
    logic [1:0]  lane_s;
    logic        trap_s;
    logic        load_acc_s;
    logic        fault_s;

    // Extract the addressed lane of a memory word and sign- or zero-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the target lane of the old memory word; all other lanes pass through.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: begin
                case (lane)
                    2'b00:   r[7:0]   = wd[7:0];
                    2'b01:   r[15:8]  = wd[7:0];
                    2'b10:   r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            2'b01: begin
                if (lane[1]) begin
                    r[31:16] = wd[15:0];
                end else begin
                    r[15:0] = wd[15:0];
                end
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    // Lane offset after aligning the address down to the access size.
    always_comb begin
        if (req_size == 2'b00) begin
            lane_s = req_addr[1:0];
        end else if (req_size == 2'b01) begin
            lane_s = {req_addr[1], 1'b0};
        end else begin
            lane_s = 2'b00;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_s = ((req_size == 2'b01) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign trap_s = 1'b0;
`endif

    // Next-state and memory-side outputs; everything is quiet while reset is held.
    always_comb begin
        state_nx_s = state_r;
        stall      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = {2'b00, req_addr[31:2]};
        mem_wdata  = req_wdata;
        load_acc_s = 1'b0;
        fault_s    = 1'b0;
        if (reset) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!req_valid) begin
                        state_nx_s = IDLE;
                    end else if (trap_s) begin
                        fault_s = 1'b1;
                    end else if (!req_write) begin
                        mem_read   = 1'b1;
                        load_acc_s = 1'b1;
                    end else if (req_size[1]) begin
                        mem_write = 1'b1;
                    end else begin
                        // Sub-word store: fetch the old word first, write the merge next cycle.
                        mem_read   = 1'b1;
                        stall      = 1'b1;
                        state_nx_s = WR;
                    end
                end
                WR: begin
                    mem_write  = 1'b1;
                    mem_wdata  = merge_r;
                    mem_addr   = waddr_r;
                    state_nx_s = IDLE;
                end
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // State register and registered writeback/fault outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            rd_valid <= 1'b0;
            rd_data  <= 32'h0000_0000;
            misalign <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            rd_valid <= load_acc_s;
            misalign <= fault_s;
            if (load_acc_s) begin
                rd_data <= load_extract(mem_rdata, lane_s, req_size, req_signed);
            end else begin
                rd_data <= rd_data;
            end
        end
    end

    // Merge buffer and write address captured on the read half of a sub-word store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            merge_r <= 32'h0000_0000;
            waddr_r <= 32'h0000_0000;
        end else if ((state_r == IDLE) && (state_nx_s == WR)) begin
            merge_r <= store_merge(mem_rdata, lane_s, req_size, req_wdata);
            waddr_r <= mem_addr;
        end else begin
            merge_r <= merge_r;
            waddr_r <= waddr_r;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array memory model plus literal expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall, mem_read, mem_write, rd_valid, misalign;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, rd_data;

    logic [31:0] dmem [0:255] = '{default: 32'h0};
    logic [7:0]  refb [0:1023] = '{default: 8'h0};

    logic        exp_stall = 1'b0, exp_rd = 1'b0, exp_wr = 1'b0;
    logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0;
    logic        exp_rv = 1'b0, exp_mis = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic        nx_rv = 1'b0, nx_mis = 1'b0;
    logic [31:0] nx_rdata = 32'h0;
    int          checks = 0;
    int          errors = 0;

    load_store_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rd_valid(rd_valid), .rd_data(rd_data),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    assign mem_rdata = dmem[mem_addr[7:0]];
    always @(posedge clk) if (mem_write) dmem[mem_addr[7:0]] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Per-cycle comparison against the model's expectations.
    always @(negedge clk) begin
        check("stall", {31'd0, stall}, {31'd0, exp_stall});
        check("mem_read", {31'd0, mem_read}, {31'd0, exp_rd});
        check("mem_write", {31'd0, mem_write}, {31'd0, exp_wr});
        check("rw_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
        if (exp_rd || exp_wr) check("mem_addr", mem_addr, exp_addr);
        if (exp_wr) check("mem_wdata", mem_wdata, exp_wdata);
        check("rd_valid", {31'd0, rd_valid}, {31'd0, exp_rv});
        check("rd_data", rd_data, exp_rdata);
        check("misalign", {31'd0, misalign}, {31'd0, exp_mis});
    end

    function automatic int nbytes_of(input logic [1:0] size);
        return size[1] ? 4 : (size[0] ? 2 : 1);
    endfunction

    function automatic logic is_mis(input logic [31:0] addr, input logic [1:0] size);
        int n;
        n = nbytes_of(size);
        return (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
    endfunction

    function automatic logic [9:0] align_of(input logic [31:0] addr, input logic [1:0] size);
        int n;
        n = nbytes_of(size);
        return addr[9:0] & ~(10'(n - 1));
    endfunction

    function automatic logic [31:0] word_at(input logic [9:0] a);
        logic [9:0] w;
        w = a & 10'h3FC;
        return {refb[w + 10'd3], refb[w + 10'd2], refb[w + 10'd1], refb[w]};
    endfunction

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        exp_rv    = nx_rv;
        exp_mis   = nx_mis;
        exp_rdata = nx_rdata;
        nx_rv     = 1'b0;
        nx_mis    = 1'b0;
        nx_rdata  = exp_rdata;
        exp_stall = 1'b0;
        exp_rd    = 1'b0;
        exp_wr    = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic drive(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_write = wr; req_size = size;
        req_signed = sgn; req_addr = addr; req_wdata = wdata;
    endtask

    task automatic issue_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
        int n;
        logic [9:0]  a;
        logic [31:0] v;
        begin_cycle();
        drive(1'b0, size, sgn, addr, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        if (is_mis(addr, size)) begin
            nx_mis = 1'b1;
            return;
        end
`endif
        n = nbytes_of(size);
        a = align_of(addr, size);
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(refb[a + 10'(i)]) << (8 * i));
        if (sgn && n < 4 && v[8 * n - 1]) v = v - (32'd1 << (8 * n));
        exp_rd   = 1'b1;
        exp_addr = {2'b00, addr[31:2]};
        nx_rv    = 1'b1;
        nx_rdata = v;
    endtask

    task automatic issue_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        int n;
        logic [9:0] a;
        begin_cycle();
        drive(1'b1, size, 1'b0, addr, wdata);
`ifdef LSU_MISALIGN_TRAP_EN
        if (is_mis(addr, size)) begin
            nx_mis = 1'b1;
            return;
        end
`endif
        n = nbytes_of(size);
        a = align_of(addr, size);
        for (int i = 0; i < n; i++) refb[a + 10'(i)] = 8'(wdata >> (8 * i));
        exp_addr = {2'b00, addr[31:2]};
        if (n == 4) begin
            exp_wr    = 1'b1;
            exp_wdata = word_at(a);
        end else begin
            exp_stall = 1'b1;
            exp_rd    = 1'b1;
            begin_cycle();
            req_valid = 1'b1;
            req_wdata = ~wdata;
            exp_wr    = 1'b1;
            exp_wdata = word_at(a);
        end
    endtask

    task automatic lit_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                            input logic sgn, input logic [31:0] want);
        issue_load(addr, size, sgn);
        begin_cycle();
        check(name, rd_data, want);
        check({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_data", rd_data, 32'h0);
        // Word store then load back.
        issue_store(32'h10, 2'b10, 32'hDEADBEEF);
        lit_load("lw_10_a", 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        issue_store(32'h11, 2'b00, 32'h0000_0055);
        lit_load("lw_10_b", 32'h10, 2'b10, 1'b0, 32'hDEAD55EF);
        issue_store(32'h10, 2'b10, 32'h8000FF80);
        lit_load("lb_10", 32'h10, 2'b00, 1'b1, 32'hFFFFFF80);
        lit_load("lbu_10", 32'h10, 2'b00, 1'b0, 32'h00000080);
        lit_load("lh_12", 32'h12, 2'b01, 1'b1, 32'hFFFF8000);
        lit_load("lhu_12", 32'h12, 2'b01, 1'b0, 32'h00008000);
        issue_store(32'h12, 2'b01, 32'h0000_1234);
        lit_load("lw_10_c", 32'h10, 2'b10, 1'b0, 32'h1234FF80);
        // Byte lanes of word 0x20, back-to-back loads, reserved size as word.
        for (int i = 0; i < 4; i++) issue_store(32'h20 + 32'(i), 2'b00, 32'(8'h11 * (i + 1)));
        lit_load("lw_20", 32'h20, 2'b10, 1'b0, 32'h44332211);
        issue_store(32'h24, 2'b11, 32'hCAFEF00D);
        issue_load(32'h26, 2'b01, 1'b0);
        issue_load(32'h27, 2'b00, 1'b1);
        lit_load("lh_22", 32'h22, 2'b01, 1'b1, 32'h00004433);
        lit_load("lb_27", 32'h27, 2'b00, 1'b1, 32'hFFFFFFCA);
        begin_cycle();
        check("rd_valid_idle", {31'd0, rd_valid}, 32'd0);
        // Reset asserted while the merged write of a byte store is pending.
        issue_store(32'h0, 2'b00, 32'h0);
        refb[10'h11] = 8'hFF;
        begin_cycle();
        drive(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA);
        exp_stall = 1'b1; exp_rd = 1'b1; exp_addr = 32'h4;
        begin_cycle();
        reset = 1'b1;
        exp_rv = 1'b0; exp_mis = 1'b0; exp_rdata = 32'h0;
        nx_rv = 1'b0; nx_mis = 1'b0; nx_rdata = 32'h0;
        #2;
        check("reset_async_rd_data", rd_data, 32'h0);
        lit_load("lw_after_reset", 32'h10, 2'b10, 1'b0, 32'h1234FF80);
        // Misaligned accesses.
`ifdef LSU_MISALIGN_TRAP_EN
        issue_load(32'h13, 2'b10, 1'b0);
        begin_cycle();
        check("lw_13_misalign", {31'd0, misalign}, 32'd1);
        check("lw_13_rd_valid", {31'd0, rd_valid}, 32'd0);
        issue_store(32'h13, 2'b01, 32'h0000_BEEF);
        lit_load("lw_10_untrapped", 32'h10, 2'b10, 1'b0, 32'h1234FF80);
`else
        lit_load("lw_13", 32'h13, 2'b10, 1'b0, 32'h1234FF80);
        lit_load("lh_13", 32'h13, 2'b01, 1'b1, 32'h00001234);
        issue_store(32'h13, 2'b01, 32'h0000_BEEF);
        lit_load("lw_10_d", 32'h10, 2'b10, 1'b0, 32'hBEEFFF80);
`endif
        repeat (3) begin_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
